dac_sample_strobe: RTL and testbench
====================================

Name: dac_sample_strobe

Overview:
Transmit-side counterpart of the receive-path ADC-ready pulse conditioning in the Zigbee IQ chain. It accepts single-cycle I/Q sample pulses from the modulator and buffers them in a small FIFO. It presents each sample to the DAC with a level-type strobe, DAC_rdy, which is held high for HIGH_CYC clocks and then low for at least LOW_CYC clocks. The block sits between the O-QPSK modulator output and the DAC interface pins.

Parameters:
IQ_W, 8, width of each of I and Q samples (two's complement, passed through unmodified)
DEPTH, 4, FIFO entries; power of two, >= 2
HIGH_CYC, 4, clocks DAC_rdy is held high per sample; >= 1
LOW_CYC, 4, minimum clocks DAC_rdy is held low between samples; >= 1

Ports:
clk  in  1  system clock
resetn  in  1  asynchronous, active-low reset
mod_valid  in  1  single-cycle pulse; mod_i/mod_q are valid in that cycle
mod_i  in  IQ_W  I sample
mod_q  in  IQ_W  Q sample
mod_ready  out  1  high when the FIFO is not full (registered count < DEPTH)
dac_i  out  IQ_W  I sample presented to the DAC
dac_q  out  IQ_W  Q sample presented to the DAC
DAC_rdy  out  1  level strobe to the DAC; data is stable while high
overflow  out  1  sticky: set when a push is attempted while full
ovf_clr  in  1  synchronous clear of overflow

Behaviour:
- Reset values (asynchronous): FSM=IDLE, FIFO empty (wr_ptr=rd_ptr=count=0), dac_i=dac_q=0, DAC_rdy=0, overflow=0, mod_ready=1. Reset mid-strobe drops DAC_rdy immediately and discards all FIFO contents.
- Push: when mod_valid=1 and count<DEPTH at a rising edge, {mod_i,mod_q} is written at wr_ptr and wr_ptr increments modulo DEPTH.
- Overflow: when mod_valid=1 and count==DEPTH, the sample is dropped and overflow is set.
  - A simultaneous pop does not rescue the push; the full decision uses the registered count.
- ovf_clr=1 clears overflow. If ovf_clr and an overflowing push coincide, set wins.
- Pop and count update: a pop and a non-full push in the same cycle leave count unchanged. Pointers wrap DEPTH-1 -> 0.
- FSM states and transitions:
  - IDLE: DAC_rdy=0. If count>0, pop and go to ASSERT.
  - ASSERT: DAC_rdy=1. hold_cnt counts HIGH_CYC cycles, then go to GAP.
  - GAP: DAC_rdy=0. gap_cnt counts LOW_CYC cycles. On the last GAP cycle, if count>0 (including a push landing that cycle? no, registered count only), pop and go directly to ASSERT; otherwise go to IDLE.
- Output loading: dac_i/dac_q load from the FIFO head on the pop edge. They remain stable through ASSERT and GAP until the next pop, and are never changed while DAC_rdy=1.
- Latency: mod_valid sampled at edge E0 into an empty FIFO with FSM in IDLE -> pop at E1 -> DAC_rdy high from E1 for exactly HIGH_CYC cycles.
- Throughput: back-to-back samples are strobed every HIGH_CYC+LOW_CYC clocks.
- Counters: hold_cnt and gap_cnt are sized $clog2(max(HIGH_CYC,LOW_CYC)+1) and reset to 0 on each state entry.
- Illegal FSM encodings recover to IDLE with DAC_rdy=0.

Decomposition:
- Shared package iq_tx_pkg: FSM enum (IDLE, ASSERT, GAP) and the default IQ_W.
- One sub-module, sample_fifo: parameterised IQ_W*2-wide, DEPTH-deep synchronous FIFO with push, pop, count, full and empty, reset on resetn.
- The FSM, counters and output registers live in dac_sample_strobe.

Test Plan:
- Single sample: reset, one mod_valid pulse with I=0x12, Q=0xF3 (HIGH=4, LOW=4) -> DAC_rdy high exactly 4 cycles starting one cycle after the push; dac_i=0x12, dac_q=0xF3 stable throughout; FSM returns to IDLE after 4 low cycles.
- Burst: 3 pulses on consecutive clocks (I=1,2,3) -> three DAC_rdy highs of 4 cycles each, separated by exactly 4 low cycles, data in order 1,2,3; mod_ready stays 1.
- Overflow: 6 consecutive pulses (I=1..6), DEPTH=4 -> samples 1..5 are output (1 is popped at the first edge, freeing a slot); 6 is dropped; overflow=1 and stays 1 until ovf_clr; ovf_clr pulse -> overflow=0.
- Pointer wrap: 10 samples spaced 8 cycles apart -> all 10 are output in order, with no DAC_rdy gap longer than LOW_CYC between queued samples.
- Reset mid-strobe: assert resetn=0 during the 2nd ASSERT cycle with 2 entries queued -> DAC_rdy=0 and dac_i=0 immediately; after release, no strobe occurs until a new mod_valid.
- Simultaneous set/clear: ovf_clr=1 in the same cycle as a full push -> overflow=1.

Source files
------------

// File: rtl/iq_tx_pkg.sv
// Shared definitions for the transmit-side IQ path.
// Contents: default IQ sample width and the DAC strobe FSM state encoding.
package iq_tx_pkg;

  localparam int unsigned IQ_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ASSERT = 2'd1,
    GAP    = 2'd2
  } strobe_state_e;

endpackage

// File: rtl/sample_fifo.sv
// Small synchronous FIFO holding packed {I,Q} samples.
// Ports:
//   clk, resetn    - clock, asynchronous active-low reset (empties the FIFO)
//   i_push, i_data - write request and data; ignored while full
//   i_pop          - read request; ignored while empty
//   o_head         - entry at the read pointer (valid when not empty)
//   o_count        - registered occupancy 0..DEPTH
//   o_full/o_empty - occupancy flags derived from o_count
module sample_fifo #(
  parameter int W     = 16,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       i_push,
  input  logic [W-1:0]               i_data,
  input  logic                       i_pop,
  output logic [W-1:0]               o_head,
  output logic [$clog2(DEPTH+1)-1:0] o_count,
  output logic                       o_full,
  output logic                       o_empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [W-1:0]     r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_push_ok;
  logic             w_pop_ok;

  assign o_full    = (r_count == CNT_W'(DEPTH));
  assign o_empty   = (r_count == CNT_W'(0));
  assign w_push_ok = i_push && !o_full;
  assign w_pop_ok  = i_pop && !o_empty;
  assign o_head    = r_mem[r_rd_ptr];
  assign o_count   = r_count;

  // Pointer and occupancy tracking; DEPTH is a power of two so pointers wrap naturally.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop_ok) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Sample storage; contents are meaningless once the pointers are reset.
  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

endmodule

// File: rtl/dac_sample_strobe.sv
// Buffers single-cycle modulator I/Q pulses and presents each sample to the
// DAC with a level strobe: DAC_rdy high for HIGH_CYC clocks, then low for at
// least LOW_CYC clocks before the next sample.
// Ports:
//   clk, resetn            - clock, asynchronous active-low reset
//   mod_valid/mod_i/mod_q  - modulator sample pulse and data
//   mod_ready              - FIFO not full (from registered occupancy)
//   dac_i/dac_q            - sample held for the DAC, changes only on a pop
//   DAC_rdy                - level strobe, data stable while high
//   overflow / ovf_clr     - sticky drop flag and its synchronous clear
module dac_sample_strobe
  import iq_tx_pkg::*;
#(
  parameter int IQ_W     = IQ_W_DEF,
  parameter int DEPTH    = 4,
  parameter int HIGH_CYC = 4,
  parameter int LOW_CYC  = 4
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            mod_valid,
  input  logic [IQ_W-1:0] mod_i,
  input  logic [IQ_W-1:0] mod_q,
  output logic            mod_ready,
  output logic [IQ_W-1:0] dac_i,
  output logic [IQ_W-1:0] dac_q,
  output logic            DAC_rdy,
  output logic            overflow,
  input  logic            ovf_clr
);

  localparam int CNT_W   = $clog2(DEPTH+1);
  localparam int TMR_MAX = (HIGH_CYC > LOW_CYC) ? HIGH_CYC : LOW_CYC;
  localparam int TMR_W   = $clog2(TMR_MAX+1);

  strobe_state_e       r_state;
  strobe_state_e       w_next;
  logic [TMR_W-1:0]    r_hold_cnt;
  logic [TMR_W-1:0]    r_gap_cnt;
  logic [TMR_W-1:0]    w_hold_nxt;
  logic [TMR_W-1:0]    w_gap_nxt;
  logic                w_pop;
  logic [2*IQ_W-1:0]   w_head;
  logic [CNT_W-1:0]    w_count;
  logic                w_full;
  logic                w_empty;
  logic [IQ_W-1:0]     r_dac_i;
  logic [IQ_W-1:0]     r_dac_q;
  logic                r_dac_rdy;
  logic                r_overflow;

  sample_fifo #(
    .W     (2*IQ_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .resetn  (resetn),
    .i_push  (mod_valid),
    .i_data  ({mod_i, mod_q}),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign mod_ready = (w_count < CNT_W'(DEPTH));
  assign dac_i     = r_dac_i;
  assign dac_q     = r_dac_q;
  assign DAC_rdy   = r_dac_rdy;
  assign overflow  = r_overflow;

  // Next-state, pop and counter logic; pops only look at registered occupancy.
  always_comb begin
    w_next     = r_state;
    w_pop      = 1'b0;
    w_hold_nxt = r_hold_cnt;
    w_gap_nxt  = r_gap_cnt;
    case (r_state)
      IDLE: begin
        if (!w_empty) begin
          w_pop      = 1'b1;
          w_next     = ASSERT;
          w_hold_nxt = '0;
        end else begin
          w_next = IDLE;
        end
      end
      ASSERT: begin
        if (r_hold_cnt == TMR_W'(HIGH_CYC-1)) begin
          w_next     = GAP;
          w_hold_nxt = '0;
          w_gap_nxt  = '0;
        end else begin
          w_hold_nxt = r_hold_cnt + TMR_W'(1);
        end
      end
      GAP: begin
        if (r_gap_cnt == TMR_W'(LOW_CYC-1)) begin
          w_gap_nxt = '0;
          if (!w_empty) begin
            // Back-to-back: skip IDLE so the period is exactly HIGH_CYC+LOW_CYC.
            w_pop      = 1'b1;
            w_next     = ASSERT;
            w_hold_nxt = '0;
          end else begin
            w_next = IDLE;
          end
        end else begin
          w_gap_nxt = r_gap_cnt + TMR_W'(1);
        end
      end
      default: begin
        w_next     = IDLE;
        w_hold_nxt = '0;
        w_gap_nxt  = '0;
      end
    endcase
  end

  // State, counters and registered strobe.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state    <= IDLE;
      r_hold_cnt <= '0;
      r_gap_cnt  <= '0;
      r_dac_rdy  <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_hold_cnt <= w_hold_nxt;
      r_gap_cnt  <= w_gap_nxt;
      r_dac_rdy  <= (w_next == ASSERT);
    end
  end

  // DAC data registers load only on a pop, so they never move while DAC_rdy is high.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_dac_i <= '0;
      r_dac_q <= '0;
    end else if (w_pop) begin
      r_dac_i <= w_head[2*IQ_W-1:IQ_W];
      r_dac_q <= w_head[IQ_W-1:0];
    end else begin
      r_dac_i <= r_dac_i;
      r_dac_q <= r_dac_q;
    end
  end

  // Sticky overflow; the full test uses registered occupancy and set beats clear.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_overflow <= 1'b0;
    end else if (mod_valid && w_full) begin
      r_overflow <= 1'b1;
    end else if (ovf_clr) begin
      r_overflow <= 1'b0;
    end else begin
      r_overflow <= r_overflow;
    end
  end

endmodule

// File: tb/tb_dac_sample_strobe.sv
module tb_dac_sample_strobe;

  localparam int IQ_W  = 8;
  localparam int DEPTH = 4;
  localparam int H     = 4;
  localparam int L     = 4;

  logic            clk = 1'b0;
  logic            resetn = 1'b0;
  logic            mod_valid = 1'b0;
  logic [IQ_W-1:0] mod_i = '0;
  logic [IQ_W-1:0] mod_q = '0;
  logic            ovf_clr = 1'b0;
  logic            mod_ready;
  logic [IQ_W-1:0] dac_i;
  logic [IQ_W-1:0] dac_q;
  logic            DAC_rdy;
  logic            overflow;

  dac_sample_strobe #(
    .IQ_W(IQ_W), .DEPTH(DEPTH), .HIGH_CYC(H), .LOW_CYC(L)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .mod_valid (mod_valid),
    .mod_i     (mod_i),
    .mod_q     (mod_q),
    .mod_ready (mod_ready),
    .dac_i     (dac_i),
    .dac_q     (dac_q),
    .DAC_rdy   (DAC_rdy),
    .overflow  (overflow),
    .ovf_clr   (ovf_clr)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model: samples waiting in the FIFO, strobe schedule by edge index.
  logic [2*IQ_W-1:0] mq[$];
  logic [2*IQ_W-1:0] sb[$];
  int  t;
  int  next_pop_t;
  int  last_pop_t;
  bit  m_ovf;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h time=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    sb.delete();
    t = 0;
    next_pop_t = 0;
    last_pop_t = -1000;
    m_ovf = 1'b0;
  endtask

  // One clock: check outputs left by the previous edge, drive inputs, advance the model.
  task automatic step(input bit v, input logic [IQ_W-1:0] i, input logic [IQ_W-1:0] q, input bit clr);
    bit full;
    @(negedge clk);
    check("mod_ready", mod_ready, (mq.size() < DEPTH));
    check("overflow", overflow, m_ovf);
    check("dac_rdy", DAC_rdy, ((t-1-last_pop_t) >= 0) && ((t-1-last_pop_t) < H));
    mod_valid = v;
    mod_i     = i;
    mod_q     = q;
    ovf_clr   = clr;
    full = (mq.size() == DEPTH);
    if (mq.size() > 0 && t >= next_pop_t) begin
      void'(mq.pop_front());
      last_pop_t = t;
      next_pop_t = t + H + L;
    end
    if (v && full) begin
      m_ovf = 1'b1;
    end else begin
      if (v) begin
        mq.push_back({i, q});
        sb.push_back({i, q});
      end
      if (clr) m_ovf = 1'b0;
    end
    t++;
    @(posedge clk);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, '0, '0, 1'b0);
  endtask

  // Reset; mid=1 asserts it shortly after the edge just taken.
  task automatic do_reset(input bit mid);
    if (mid) #2;
    else @(negedge clk);
    resetn    = 1'b0;
    mod_valid = 1'b0;
    ovf_clr   = 1'b0;
    #1;
    check("rst_dac_rdy", DAC_rdy, 1'b0);
    check("rst_dac_i", dac_i, '0);
    check("rst_dac_q", dac_q, '0);
    check("rst_overflow", overflow, 1'b0);
    check("rst_mod_ready", mod_ready, 1'b1);
    model_reset();
    repeat (2) @(negedge clk);
    resetn = 1'b1;
  endtask

  // Monitor: on each strobe compare data to the scoreboard, check hold length and gap.
  logic              mon_high = 1'b0;
  int                hi_len = 0;
  int                lo_len = L;
  logic [2*IQ_W-1:0] held;
  logic [2*IQ_W-1:0] mon_exp;

  always @(negedge clk) begin
    if (!resetn) begin
      mon_high = 1'b0;
      hi_len   = 0;
      lo_len   = L;
    end else if (DAC_rdy && !mon_high) begin
      check("gap_min", (lo_len >= L), 1'b1);
      if (sb.size() == 0) begin
        check("unexpected_strobe", 1'b1, 1'b0);
      end else begin
        mon_exp = sb.pop_front();
        check("strobe_dac_i", dac_i, mon_exp[2*IQ_W-1:IQ_W]);
        check("strobe_dac_q", dac_q, mon_exp[IQ_W-1:0]);
      end
      held     = {dac_i, dac_q};
      hi_len   = 1;
      mon_high = 1'b1;
    end else if (DAC_rdy) begin
      hi_len++;
      check("data_stable", {dac_i, dac_q}, held);
    end else if (mon_high) begin
      check("high_len", hi_len, H);
      mon_high = 1'b0;
      lo_len   = 1;
    end else begin
      lo_len++;
    end
  end

  initial begin
    model_reset();
    do_reset(1'b0);

    // Single sample
    step(1'b1, 8'h12, 8'hF3, 1'b0);
    idle(14);

    // Burst of three
    for (int k = 1; k <= 3; k++) step(1'b1, IQ_W'(k), IQ_W'(8'h40 + k), 1'b0);
    idle(30);

    // Overflow: six pulses, 6th dropped; flag sticks until cleared
    for (int k = 1; k <= 6; k++) step(1'b1, IQ_W'(k), IQ_W'(8'h80 + k), 1'b0);
    #1 check("ovf_after_burst", overflow, 1'b1);
    idle(10);
    #1 check("ovf_sticky", overflow, 1'b1);
    step(1'b0, '0, '0, 1'b1);
    #1 check("ovf_cleared", overflow, 1'b0);
    idle(45);

    // Pointer wrap: ten samples eight cycles apart
    for (int k = 0; k < 10; k++) begin
      step(1'b1, IQ_W'(8'hA0 + k), IQ_W'(8'h0F - k), 1'b0);
      idle(7);
    end
    idle(20);

    // Set beats clear: fill, then overflowing push together with ovf_clr
    for (int k = 0; k < 5; k++) step(1'b1, IQ_W'(8'h30 + k), IQ_W'(k), 1'b0);
    step(1'b1, 8'h3F, 8'h3F, 1'b1);
    #1 check("ovf_set_wins", overflow, 1'b1);
    idle(45);

    // Reset mid-strobe: second ASSERT cycle with two entries queued
    do_reset(1'b0);
    step(1'b1, 8'h51, 8'h61, 1'b0);
    step(1'b1, 8'h52, 8'h62, 1'b0);
    step(1'b1, 8'h53, 8'h63, 1'b0);
    do_reset(1'b1);
    idle(20);

    // Randomized traffic
    for (int k = 0; k < 400; k++) begin
      step(($urandom_range(0, 99) < 35), IQ_W'($urandom), IQ_W'($urandom),
           ($urandom_range(0, 24) == 0));
    end
    idle(50);

    check("scoreboard_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Hard time limit so the bench can never hang.
  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
